// File: rtl/priority_resolver.sv
// priority_resolver: IRR/ISR bookkeeping and rotating-priority resolution for an
// 8259-style interrupt controller. Feeds INTERNAL_INT and IR_NUM to the control unit.
// Optional feature macro: PIC_SPECIAL_MASK_EN. When it is defined, SMM=1 stops the
// ISR from inhibiting lower levels. When it is undefined, SMM is ignored and
// nesting is always fully nested.
module priority_resolver (
  input  logic       CLK,
  input  logic       RST_,
  input  logic [7:0] IR,
  input  logic       LEVEL,
  input  logic [7:0] interrupt_mask,
  input  logic       INTA_FIRST,
  input  logic       INTA_LAST,
  input  logic       AEOI,
  input  logic       ROTATE,
  input  logic       EOI_NS,
  input  logic       EOI_SPEC,
  input  logic [2:0] EOI_LEVEL,
  input  logic       SET_PRIO,
  input  logic [2:0] PRIO_LEVEL,
  input  logic       SMM,
  output logic       INTERNAL_INT,
  output logic [2:0] IR_NUM,
  output logic [7:0] IRR,
  output logic [7:0] ISR
);

  logic [7:0] ir_q;
  logic [2:0] lp;        // lowest-priority level; LP+1 is the highest priority

  logic       smm_act;
  logic [7:0] cand;
  logic       win_valid;
  logic [2:0] win_lvl;
  logic [2:0] win_rank;
  logic       isr_valid;
  logic [2:0] isr_lvl;
  logic [2:0] isr_rank;
  logic       int_next;
  logic [7:0] isr_set;
  logic [7:0] isr_clr;
  logic [7:0] irr_ack;
  logic [7:0] irr_next;
  logic [7:0] isr_next;
  logic [2:0] lp_next;
  logic [2:0] num_next;

`ifdef PIC_SPECIAL_MASK_EN
  assign smm_act = SMM;
`else
  logic unused_smm;
  assign unused_smm = SMM;
  assign smm_act    = 1'b0;
`endif

  // In special mask mode, levels that are already in service are not eligible
  // to win. Masked levels are excluded in either mode.
  assign cand = IRR & ~interrupt_mask & (smm_act ? ~ISR : 8'hFF);

  // Find the highest-priority candidate and the highest-priority in-service level.
  // The scan runs from lowest to highest priority, so the last hit found is the winner.
  always_comb begin
    logic [2:0] lvl;
    win_valid = 1'b0;
    win_lvl   = 3'd0;
    win_rank  = 3'd7;
    isr_valid = 1'b0;
    isr_lvl   = 3'd0;
    isr_rank  = 3'd7;
    lvl       = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      lvl = lp + 3'(k + 1);
      if (cand[lvl]) begin
        win_valid = 1'b1;
        win_lvl   = lvl;
        win_rank  = 3'(k);
      end
      if (ISR[lvl]) begin
        isr_valid = 1'b1;
        isr_lvl   = lvl;
        isr_rank  = 3'(k);
      end
    end
  end

  // Raise the request only when the winner outranks everything in service.
  // In special mask mode the ISR does not inhibit lower levels.
  assign int_next = win_valid && (smm_act || !isr_valid || (win_rank < isr_rank));

  // Command decode. At most one ISR-clearing or LP-changing command is applied per
  // cycle. The acknowledge is handled separately so that it can share the cycle.
  always_comb begin
    isr_clr = 8'h00;
    lp_next = lp;
    if (SET_PRIO) begin
      lp_next = PRIO_LEVEL;
    end else if (EOI_SPEC) begin
      isr_clr[EOI_LEVEL] = 1'b1;
      if (ROTATE) lp_next = EOI_LEVEL;
    end else if (EOI_NS) begin
      if (isr_valid) begin
        isr_clr[isr_lvl] = 1'b1;
        if (ROTATE) lp_next = isr_lvl;
      end
    end else if (INTA_LAST && AEOI) begin
      isr_clr[IR_NUM] = 1'b1;
      if (ROTATE) lp_next = IR_NUM;
    end
  end

  // Acknowledge path and next-value computation for IRR, ISR and IR_NUM.
  // An ISR set takes precedence over a clear that targets the same bit.
  always_comb begin
    isr_set  = 8'h00;
    irr_ack  = 8'h00;
    num_next = IR_NUM;
    if (INTA_FIRST) begin
      if (win_valid) begin
        isr_set[win_lvl] = 1'b1;
        irr_ack[win_lvl] = 1'b1;
        num_next         = win_lvl;
      end else begin
        num_next = 3'd7;
      end
    end
    if (LEVEL)
      irr_next = IR;
    else
      irr_next = IR & (IRR | ~ir_q) & ~irr_ack;
    isr_next = (ISR & ~isr_clr) | isr_set;
  end

  // State registers. ir_q resets to 0, so an IR line held high through reset
  // release is treated as a rising edge.
  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      ir_q         <= 8'h00;
      IRR          <= 8'h00;
      ISR          <= 8'h00;
      lp           <= 3'd7;
      IR_NUM       <= 3'd0;
      INTERNAL_INT <= 1'b0;
    end else begin
      ir_q         <= IR;
      IRR          <= irr_next;
      ISR          <= isr_next;
      lp           <= lp_next;
      IR_NUM       <= num_next;
      INTERNAL_INT <= int_next;
    end
  end

endmodule

// File: tb/tb_priority_resolver.sv
// Bench for priority_resolver. Stimulus pushes time-stamped expectations into a
// scoreboard queue, and a monitor compares each one on the falling edge at which it is due.
module tb_priority_resolver;

  localparam int S_IRR = 0;
  localparam int S_ISR = 1;
  localparam int S_INT = 2;
  localparam int S_NUM = 3;

  logic       CLK = 1'b0;
  logic       RST_;
  logic [7:0] IR;
  logic       LEVEL;
  logic [7:0] interrupt_mask;
  logic       INTA_FIRST, INTA_LAST, AEOI, ROTATE, EOI_NS, EOI_SPEC, SET_PRIO, SMM;
  logic [2:0] EOI_LEVEL, PRIO_LEVEL;
  logic       INTERNAL_INT;
  logic [2:0] IR_NUM;
  logic [7:0] IRR, ISR;

  typedef struct {
    int         due;
    int         sel;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  priority_resolver dut (
    .CLK(CLK), .RST_(RST_), .IR(IR), .LEVEL(LEVEL), .interrupt_mask(interrupt_mask),
    .INTA_FIRST(INTA_FIRST), .INTA_LAST(INTA_LAST), .AEOI(AEOI), .ROTATE(ROTATE),
    .EOI_NS(EOI_NS), .EOI_SPEC(EOI_SPEC), .EOI_LEVEL(EOI_LEVEL), .SET_PRIO(SET_PRIO),
    .PRIO_LEVEL(PRIO_LEVEL), .SMM(SMM), .INTERNAL_INT(INTERNAL_INT), .IR_NUM(IR_NUM),
    .IRR(IRR), .ISR(ISR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  function automatic logic [7:0] pick(int s);
    case (s)
      S_IRR:   return IRR;
      S_ISR:   return ISR;
      S_INT:   return {7'd0, INTERNAL_INT};
      default: return {5'd0, IR_NUM};
    endcase
  endfunction

  // Monitor: on each falling edge, compare every entry that is due this cycle.
  always @(negedge CLK) begin
    logic [7:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        act = pick(sb[i].sel);
        total++;
        if (sb[i].due < cyc)
          $display("FAIL %s: check missed its cycle (due %0d, now %0d)", sb[i].name, sb[i].due, cyc);
        else if (act === sb[i].val)
          passed++;
        else
          $display("FAIL %s: got 0x%02h, expected 0x%02h (cycle %0d)", sb[i].name, act, sb[i].val, cyc);
        sb.delete(i);
      end
    end
  end

  task automatic want(string n, int s, logic [7:0] v, int d);
    sb.push_back('{due: cyc + d, sel: s, val: v, name: n});
  endtask

  task automatic adv(int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_ = 1'b0; IR = 8'h00; LEVEL = 1'b0; interrupt_mask = 8'h00;
    INTA_FIRST = 1'b0; INTA_LAST = 1'b0; AEOI = 1'b0; ROTATE = 1'b0;
    EOI_NS = 1'b0; EOI_SPEC = 1'b0; EOI_LEVEL = 3'd0; SET_PRIO = 1'b0;
    PRIO_LEVEL = 3'd0; SMM = 1'b0;
    adv(3);
    RST_ = 1'b1;
    want("rst_irr", S_IRR, 8'h00, 1); want("rst_isr", S_ISR, 8'h00, 1);
    want("rst_int", S_INT, 8'h00, 1); want("rst_num", S_NUM, 8'h00, 1);
    adv(2);

    // Edge request on IR2, then acknowledge.
    IR = 8'h04;
    want("t1_irr", S_IRR, 8'h04, 1); want("t1_int", S_INT, 8'h01, 2);
    adv(2);
    INTA_FIRST = 1'b1;
    want("t1_num", S_NUM, 8'h02, 1); want("t1_isr", S_ISR, 8'h04, 1);
    want("t1_irr_ack", S_IRR, 8'h00, 1); want("t1_int_drop", S_INT, 8'h00, 2);
    adv(1); INTA_FIRST = 1'b0; adv(2);

    // Nesting: IR5 is blocked by IR2 in service, while IR1 preempts it.
    IR = 8'h24;
    want("t2_irr5", S_IRR, 8'h20, 1); want("t2_int_blocked", S_INT, 8'h00, 2);
    adv(3);
    IR = 8'h26;
    want("t2_irr1", S_IRR, 8'h22, 1); want("t2_int_nest", S_INT, 8'h01, 2);
    adv(2);
    INTA_FIRST = 1'b1;
    want("t2_num1", S_NUM, 8'h01, 1); want("t2_isr06", S_ISR, 8'h06, 1);
    want("t2_irr20", S_IRR, 8'h20, 1);
    adv(1); INTA_FIRST = 1'b0;
    want("t2_int_after_ack", S_INT, 8'h00, 1);
    EOI_NS = 1'b1; want("t2_eoi_first", S_ISR, 8'h04, 1);
    adv(1); EOI_NS = 1'b0; adv(1);
    EOI_NS = 1'b1; want("t2_eoi_second", S_ISR, 8'h00, 1);
    adv(1); EOI_NS = 1'b0;
    want("t2_int_ir5", S_INT, 8'h01, 1);
    adv(1);
    INTA_FIRST = 1'b1; want("t2_num5", S_NUM, 8'h05, 1); want("t2_isr20", S_ISR, 8'h20, 1);
    adv(1); INTA_FIRST = 1'b0;
    EOI_NS = 1'b1; want("t2_isr_clean", S_ISR, 8'h00, 1);
    adv(1); EOI_NS = 1'b0; IR = 8'h00; adv(2);

    // Full mask, spurious acknowledge, then unmask.
    interrupt_mask = 8'hFF; IR = 8'h80;
    want("t3_irr", S_IRR, 8'h80, 1); want("t3_int_masked", S_INT, 8'h00, 2);
    adv(2);
    INTA_FIRST = 1'b1;
    want("t3_spur_num", S_NUM, 8'h07, 1); want("t3_spur_isr", S_ISR, 8'h00, 1);
    want("t3_spur_irr", S_IRR, 8'h80, 1);
    adv(1); INTA_FIRST = 1'b0;
    interrupt_mask = 8'h00; want("t3_int_unmask", S_INT, 8'h01, 1);
    adv(1);
    IR = 8'h00; want("t3_irr_drop", S_IRR, 8'h00, 1); want("t3_int_drop", S_INT, 8'h00, 2);
    adv(3);

    // Rotation: specific EOI to level 3 makes IR4 the highest priority.
    ROTATE = 1'b1; EOI_SPEC = 1'b1; EOI_LEVEL = 3'd3;
    adv(1); ROTATE = 1'b0; EOI_SPEC = 1'b0;
    IR = 8'h18;
    want("t4_irr", S_IRR, 8'h18, 1); want("t4_int", S_INT, 8'h01, 2);
    adv(2);
    INTA_FIRST = 1'b1;
    want("t4_num_rot", S_NUM, 8'h04, 1); want("t4_isr", S_ISR, 8'h10, 1);
    want("t4_irr_left", S_IRR, 8'h08, 1);
    adv(1); INTA_FIRST = 1'b0;
    EOI_NS = 1'b1; want("t4_eoi", S_ISR, 8'h00, 1); want("t4_int3", S_INT, 8'h01, 2);
    adv(1); EOI_NS = 1'b0; adv(1);
    INTA_FIRST = 1'b1; want("t4_num3", S_NUM, 8'h03, 1); want("t4_isr08", S_ISR, 8'h08, 1);
    adv(1); INTA_FIRST = 1'b0;
    // SET_PRIO outranks EOI_SPEC in the same cycle, so ISR must be left alone.
    SET_PRIO = 1'b1; PRIO_LEVEL = 3'd7; EOI_SPEC = 1'b1; EOI_LEVEL = 3'd3;
    want("t4_strobe_prio", S_ISR, 8'h08, 1);
    adv(1); SET_PRIO = 1'b0;
    want("t4_spec_eoi", S_ISR, 8'h00, 1);
    adv(1); EOI_SPEC = 1'b0; IR = 8'h00; adv(2);

    // AEOI. IR0 must win with LP restored to 7; IR7 stays pending.
    AEOI = 1'b1; IR = 8'h81;
    want("t5_irr", S_IRR, 8'h81, 1); want("t5_int", S_INT, 8'h01, 2);
    adv(2);
    INTA_FIRST = 1'b1; want("t5_num0", S_NUM, 8'h00, 1); want("t5_isr01", S_ISR, 8'h01, 1);
    adv(1); INTA_FIRST = 1'b0;
    INTA_LAST = 1'b1; want("t5_aeoi0", S_ISR, 8'h00, 1);
    adv(1); INTA_LAST = 1'b0; adv(1);
    INTA_FIRST = 1'b1; want("t5_num7", S_NUM, 8'h07, 1); want("t5_isr80", S_ISR, 8'h80, 1);
    adv(1); INTA_FIRST = 1'b0;
    INTA_LAST = 1'b1; want("t5_aeoi7", S_ISR, 8'h00, 1);
    adv(1); INTA_LAST = 1'b0; AEOI = 1'b0; IR = 8'h00; adv(2);

    // Level mode: a request that drops before the acknowledge disappears.
    LEVEL = 1'b1; IR = 8'h10;
    want("t6_lvl_irr", S_IRR, 8'h10, 1);
    adv(1);
    IR = 8'h00;
    want("t6_lvl_drop", S_IRR, 8'h00, 1); want("t6_lvl_int", S_INT, 8'h00, 2);
    adv(3); LEVEL = 1'b0;

    // Special mask: IR0 is in service and IR6 is requested.
    IR = 8'h01; adv(2);
    INTA_FIRST = 1'b1; want("t7_isr01", S_ISR, 8'h01, 1);
    adv(1); INTA_FIRST = 1'b0;
    SMM = 1'b1; IR = 8'h41;
    want("t7_irr40", S_IRR, 8'h40, 1);
`ifdef PIC_SPECIAL_MASK_EN
    want("t7_smm_int", S_INT, 8'h01, 2);
`else
    want("t7_smm_int", S_INT, 8'h00, 2);
`endif
    adv(2); SMM = 1'b0;
    EOI_NS = 1'b1; want("t7_eoi", S_ISR, 8'h00, 1);
    adv(1); EOI_NS = 1'b0; adv(1);
    INTA_FIRST = 1'b1; want("t7_num6", S_NUM, 8'h06, 1);
    adv(1); INTA_FIRST = 1'b0;
    EOI_NS = 1'b1; adv(1); EOI_NS = 1'b0; IR = 8'h00; adv(2);

    // Reset in mid-sequence. IR1 is held high across reset release.
    IR = 8'h02; adv(2);
    INTA_FIRST = 1'b1; want("t8_isr02", S_ISR, 8'h02, 1);
    adv(1); INTA_FIRST = 1'b0;
    RST_ = 1'b0;
    want("t8_rst_isr", S_ISR, 8'h00, 1); want("t8_rst_num", S_NUM, 8'h00, 1);
    want("t8_rst_irr", S_IRR, 8'h00, 1);
    adv(1);
    RST_ = 1'b1; AEOI = 1'b1; INTA_LAST = 1'b1;
    want("t8_edge_irr", S_IRR, 8'h02, 1); want("t8_isr_stay", S_ISR, 8'h00, 1);
    want("t8_int", S_INT, 8'h01, 2);
    adv(1); INTA_LAST = 1'b0; AEOI = 1'b0;
    adv(3);

    if (sb.size() != 0) begin
      total++;
      $display("FAIL leftover: %0d checks never evaluated, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
